// File: rtl/rgb_batch_packer.sv
// rgb_batch_packer
//
// Packs a multi-channel pixel stream into fixed-size batches for the matrix
// output path. A batch closes when it is full or when a pixel marked as the
// end of its line arrives. A short batch has its unused slots padded.
// There are two storage stages:
//   - fill buffer: collects pixels. It also holds one closed batch while
//     the output register is still occupied.
//   - output register: presents a batch under a valid/ready handshake.
// A pixel that arrives while both stages are occupied, and no handshake
// frees the output register, is dropped. O_overflow then pulses for one cycle.
//
// Ports:
//   I_rgb_clk      clock, all logic on the rising edge
//   I_rst          synchronous active-high reset
//   I_color        pixel, channel 0 in the LSBs
//   I_color_valid  pixel present this cycle
//   I_line_end     pixel is the last of its line (qualified by I_color_valid)
//   O_batch_valid  output batch present
//   I_batch_ready  consumer accepts the batch while O_batch_valid is high
//   O_batch_color  batch pixels, pixel i in slot i
//   O_batch_count  number of real pixels in the batch
//   O_batch_last   batch was closed by a line end
//   O_overflow     one-cycle pulse per dropped pixel

module rgb_batch_packer #(
  parameter int                     COLOR_WIDTH = 8,
  parameter int                     CHANNELS    = 3,
  parameter int                     BATCH_SIZE  = 8,
  parameter logic [COLOR_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                                        I_rgb_clk,
  input  logic                                        I_rst,
  input  logic [CHANNELS*COLOR_WIDTH-1:0]             I_color,
  input  logic                                        I_color_valid,
  input  logic                                        I_line_end,
  output logic                                        O_batch_valid,
  input  logic                                        I_batch_ready,
  output logic [BATCH_SIZE*CHANNELS*COLOR_WIDTH-1:0]  O_batch_color,
  output logic [$clog2(BATCH_SIZE+1)-1:0]             O_batch_count,
  output logic                                        O_batch_last,
  output logic                                        O_overflow
);

  localparam int PIX_W   = CHANNELS * COLOR_WIDTH;
  localparam int BATCH_W = BATCH_SIZE * PIX_W;
  localparam int CNT_W   = $clog2(BATCH_SIZE + 1);
  localparam int IDX_W   = $clog2(BATCH_SIZE);

  localparam logic [PIX_W-1:0] PAD_PIXEL = {CHANNELS{PAD_VALUE}};

  typedef enum logic {
    ST_FILL,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BATCH_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]    hold_count_q, hold_count_d;
  logic                hold_last_q, hold_last_d;
  logic                out_valid_q, out_valid_d;
  logic [BATCH_W-1:0]  out_color_q, out_color_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic                out_last_q, out_last_d;
  logic                overflow_q, overflow_d;

  logic                handshake;
  logic [BATCH_W-1:0]  written;
  logic [BATCH_W-1:0]  closed;

  // Write one pixel into the slot selected by idx.
  function automatic logic [BATCH_W-1:0] write_slot(
    input logic [BATCH_W-1:0] batch_in,
    input logic [IDX_W-1:0]   idx,
    input logic [PIX_W-1:0]   pix
  );
    logic [BATCH_W-1:0] r;
    r = batch_in;
    for (int i = 0; i < BATCH_SIZE; i++) begin
      if (IDX_W'(i) == idx) begin
        r[i*PIX_W +: PIX_W] = pix;
      end
    end
    return r;
  endfunction

  // Replace every slot after the last real pixel with the pad pixel. This
  // clears any stale pixels left over from an earlier batch.
  function automatic logic [BATCH_W-1:0] pad_after(
    input logic [BATCH_W-1:0] batch_in,
    input logic [IDX_W-1:0]   idx
  );
    logic [BATCH_W-1:0] r;
    r = batch_in;
    for (int i = 0; i < BATCH_SIZE; i++) begin
      if (i > int'(idx)) begin
        r[i*PIX_W +: PIX_W] = PAD_PIXEL;
      end
    end
    return r;
  endfunction

  assign handshake = out_valid_q && I_batch_ready;

  // Next-state logic for the fill buffer, the output register and the
  // overflow pulse. A handshake empties the output register unless a new
  // batch is loaded on the same edge, so there are no bubbles between batches.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    hold_count_d = hold_count_q;
    hold_last_d  = hold_last_q;
    out_valid_d  = out_valid_q;
    out_color_d  = out_color_q;
    out_count_d  = out_count_q;
    out_last_d   = out_last_q;
    overflow_d   = 1'b0;
    written      = '0;
    closed       = '0;

    if (handshake) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (I_color_valid) begin
          written = write_slot(fill_q, idx_q, I_color);
          if ((idx_q == IDX_W'(BATCH_SIZE - 1)) || I_line_end) begin
            closed = pad_after(written, idx_q);
            idx_d  = '0;
            if (!out_valid_q || handshake) begin
              out_valid_d = 1'b1;
              out_color_d = closed;
              out_count_d = CNT_W'(idx_q) + CNT_W'(1);
              out_last_d  = I_line_end;
            end else begin
              // The output register is busy, so keep the batch in the fill buffer.
              fill_d       = closed;
              hold_count_d = CNT_W'(idx_q) + CNT_W'(1);
              hold_last_d  = I_line_end;
              state_d      = ST_HOLD;
            end
          end else begin
            fill_d = written;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b1;
          out_color_d = fill_q;
          out_count_d = hold_count_q;
          out_last_d  = hold_last_q;
          state_d     = ST_FILL;
          idx_d       = '0;
          // The fill buffer is free again, so a pixel arriving on this edge
          // starts the next batch in slot 0.
          if (I_color_valid) begin
            written = write_slot(fill_q, '0, I_color);
            if (I_line_end) begin
              fill_d       = pad_after(written, '0);
              hold_count_d = CNT_W'(1);
              hold_last_d  = 1'b1;
              state_d      = ST_HOLD;
            end else begin
              fill_d = written;
              idx_d  = IDX_W'(1);
            end
          end
        end else if (I_color_valid) begin
          overflow_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State registers. Reset discards the partial batch and the held batch,
  // and clears the output register.
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      fill_q       <= '0;
      hold_count_q <= '0;
      hold_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_color_q  <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      hold_count_q <= hold_count_d;
      hold_last_q  <= hold_last_d;
      out_valid_q  <= out_valid_d;
      out_color_q  <= out_color_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign O_batch_valid = out_valid_q;
  assign O_batch_color = out_color_q;
  assign O_batch_count = out_count_q;
  assign O_batch_last  = out_last_q;
  assign O_overflow    = overflow_q;

endmodule

// File: tb/tb_rgb_batch_packer.sv
// tb_rgb_batch_packer
//
// Testbench for rgb_batch_packer with BATCH_SIZE=4, CHANNELS=3,
// COLOR_WIDTH=8 and PAD_VALUE=0xAA. The driver runs a behavioural model
// that works on whole batches: it keeps a queue of pixels per batch and a
// count of batches still inside the packer. The expected batches go into a
// scoreboard queue. A separate monitor compares every cycle and pops a batch
// when it is handed off.

module tb_rgb_batch_packer;

  localparam int CW   = 8;
  localparam int CH   = 3;
  localparam int BS   = 4;
  localparam int P    = CH * CW;
  localparam int BW   = BS * P;
  localparam int CNTW = $clog2(BS + 1);
  localparam logic [CW-1:0] PAD = 8'hAA;

  logic            clk;
  logic            I_rst;
  logic [P-1:0]    I_color;
  logic            I_color_valid;
  logic            I_line_end;
  logic            O_batch_valid;
  logic            I_batch_ready;
  logic [BW-1:0]   O_batch_color;
  logic [CNTW-1:0] O_batch_count;
  logic            O_batch_last;
  logic            O_overflow;

  rgb_batch_packer #(
    .COLOR_WIDTH (CW),
    .CHANNELS    (CH),
    .BATCH_SIZE  (BS),
    .PAD_VALUE   (PAD)
  ) dut (
    .I_rgb_clk     (clk),
    .I_rst         (I_rst),
    .I_color       (I_color),
    .I_color_valid (I_color_valid),
    .I_line_end    (I_line_end),
    .O_batch_valid (O_batch_valid),
    .I_batch_ready (I_batch_ready),
    .O_batch_color (O_batch_color),
    .O_batch_count (O_batch_count),
    .O_batch_last  (O_batch_last),
    .O_overflow    (O_overflow)
  );

  typedef struct {
    logic [BW-1:0]   color;
    logic [CNTW-1:0] count;
    logic            last;
  } batch_t;

  batch_t       exp_q[$];
  logic [P-1:0] cur[$];
  int           pending;
  logic         exp_ovf;
  logic         mon_en;
  int           check_cnt;
  int           pass_cnt;

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stop a hung simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of input and advance the model.
  // A pixel is dropped only if two closed batches are already inside the
  // packer and this cycle's handshake does not free one of them.
  task automatic applyStimulus(input logic v, input logic le, input logic rdy,
                               input logic [P-1:0] col);
    int     hs;
    int     closes;
    logic   drop;
    batch_t b;
    hs     = (pending > 0 && rdy) ? 1 : 0;
    closes = 0;
    drop   = 1'b0;
    b.color = '0;
    b.count = '0;
    b.last  = 1'b0;
    if (v) begin
      if (pending - hs < 2) begin
        cur.push_back(col);
        if (cur.size() == BS || le) begin
          for (int i = 0; i < BS; i++) begin
            b.color[i*P +: P] = (i < cur.size()) ? cur[i] : {CH{PAD}};
          end
          b.count = CNTW'(cur.size());
          b.last  = le;
          cur.delete();
          closes = 1;
        end
      end else begin
        drop = 1'b1;
      end
    end
    pending = pending - hs + closes;
    I_color_valid = v;
    I_line_end    = le;
    I_batch_ready = rdy;
    I_color       = col;
    @(posedge clk);
    #1;
    if (closes != 0) exp_q.push_back(b);
    exp_ovf = drop;
  endtask

  // Pulse reset for one cycle, with a valid pixel optionally present to show
  // that reset wins. Then check that every output is cleared.
  task automatic doReset(input logic v);
    I_rst         = 1'b1;
    I_color_valid = v;
    I_line_end    = 1'b0;
    I_batch_ready = 1'b0;
    I_color       = P'($urandom);
    @(posedge clk);
    #1;
    I_rst         = 1'b0;
    I_color_valid = 1'b0;
    exp_q.delete();
    cur.delete();
    pending = 0;
    exp_ovf = 1'b0;
    checkOutput("rst_valid", O_batch_valid, 0);
    checkOutput("rst_color", O_batch_color, 0);
    checkOutput("rst_count", O_batch_count, 0);
    checkOutput("rst_last",  O_batch_last,  0);
    checkOutput("rst_ovf",   O_overflow,    0);
  endtask

  // Monitor: samples on the falling edge. It checks valid and overflow
  // every cycle, checks the presented batch against the scoreboard head,
  // and pops the head when the batch is handed off.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("mon_valid", O_batch_valid, (exp_q.size() != 0));
      checkOutput("mon_overflow", O_overflow, exp_ovf);
      if (O_batch_valid && exp_q.size() != 0) begin
        checkOutput("mon_color", O_batch_color, exp_q[0].color);
        checkOutput("mon_count", O_batch_count, exp_q[0].count);
        checkOutput("mon_last",  O_batch_last,  exp_q[0].last);
        if (I_batch_ready) exp_q.pop_front();
      end
    end
  end

  initial begin
    check_cnt     = 0;
    pass_cnt      = 0;
    mon_en        = 1'b0;
    pending       = 0;
    exp_ovf       = 1'b0;
    I_rst         = 1'b1;
    I_color       = '0;
    I_color_valid = 1'b0;
    I_line_end    = 1'b0;
    I_batch_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    I_rst = 1'b0;
    checkOutput("init_valid", O_batch_valid, 0);
    checkOutput("init_color", O_batch_color, 0);
    checkOutput("init_count", O_batch_count, 0);
    checkOutput("init_last",  O_batch_last,  0);
    checkOutput("init_ovf",   O_overflow,    0);
    mon_en = 1'b1;

    // Continuous stream with ready held high produces two full batches.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, {CH{8'(k)}});
      if (k == 3) begin
        checkOutput("lat_valid", O_batch_valid, 1);
        checkOutput("lat_color", O_batch_color, 96'h030303_020202_010101_000000);
        checkOutput("lat_count", O_batch_count, 4);
        checkOutput("lat_last",  O_batch_last,  0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // A line of six pixels gives a full batch and then a padded batch of two.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, (k == 5), 1'b1, {CH{8'(8'h10 + k)}});
    end
    checkOutput("pad_color", O_batch_color, 96'hAAAAAA_AAAAAA_151515_141414);
    checkOutput("pad_count", O_batch_count, 2);
    checkOutput("pad_last",  O_batch_last,  1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // With ready held low for 12 cycles, the packer fills both stages and
    // then drops pixels.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, {CH{8'(8'h20 + k)}});
    end

    // One handshake cycle while holding: the pixel lands in the new batch.
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h555555);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, {CH{8'(8'h60 + k)}});
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // A line end on the pixel that fills the batch closes one batch only.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, (k == 3), 1'b1, {CH{8'(8'h70 + k)}});
    end
    checkOutput("full_le_count", O_batch_count, 4);
    checkOutput("full_le_last",  O_batch_last,  1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("full_le_no_extra", O_batch_valid, 0);

    // Reset in the middle of a batch, then reset while a batch is presented.
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h818181);
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h828282);
    doReset(1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, {CH{8'(8'h90 + k)}});
    end
    doReset(1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, {CH{8'(8'hA0 + k)}});
    end
    checkOutput("post_rst_color", O_batch_color, 96'hA3A3A3_A2A2A2_A1A1A1_A0A0A0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // Random traffic with back-pressure and line ends.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 99) < 80), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 99) < 60), P'($urandom));
    end

    // Drain the packer, within a bounded number of cycles.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
    end
    checkOutput("drain_valid", O_batch_valid, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
